wshb_fb_reader: RTL and testbench
=================================

// Module: wshb_fb_reader
// PURPOSE
//  Wishbone master that streams the frame buffer out of SDRAM for display. Reads one 16-bit
//  pixel per classic Wishbone cycle through the VGA slave port of the SDRAM interconnect.
//  Buffers pixels in an internal FWFT FIFO and presents a valid/ready pixel stream to the
//  VGA timing generator. Restarts at the frame base address on every frame_start pulse.
// PARAMETERS
//  HDISP      640   active pixels per line
//  VDISP      480   active lines per frame
//  FIFO_DEPTH 256   pixel FIFO depth, power of 2, >=4
//  BASE_ADDR  0     byte address of pixel (0,0) in SDRAM
// PORTS
//  clk          in   1   system clock (Wishbone clock)
//  rst          in   1   synchronous reset, active-high
//  wb_cyc       out  1   Wishbone cycle, always equal to wb_stb
//  wb_stb       out  1   Wishbone strobe
//  wb_we        out  1   constant 0 (read-only master)
//  wb_sel       out  2   constant 2'b11
//  wb_cti       out  3   constant 0 (classic)
//  wb_bte       out  2   constant 0
//  wb_adr       out  32  byte address of current read
//  wb_dat_sm    in   16  read data from slave
//  wb_ack       in   1   slave acknowledge
//  frame_start  in   1   1-cycle pulse: new frame begins, restart fetch
//  pix_rdy      in   1   display consumes pix_data this cycle
//  pix_data     out  16  FIFO head pixel (RGB565)
//  pix_valid    out  1   FIFO not empty
//  underflow    out  1   sticky: display requested a pixel while FIFO was empty
// BEHAVIOUR
//  Reset: every output 0, FIFO empty, pixel counter 0, state IDLE. wb_sel still 2'b11.
//  FSM states: IDLE, FETCH, ABORT, DONE.
//   IDLE : stb=0; frame_start -> flush FIFO, adr<=BASE_ADDR, cnt<=0, -> FETCH.
//   FETCH: stb rises only when FIFO count < FIFO_DEPTH-1. Once high, stb and adr stay
//          stable until wb_ack. On ack: push wb_dat_sm into FIFO, adr+=2, cnt+=1, stb->0.
//          stb may re-rise on the next cycle (1 cycle min gap between reads).
//          Ack of pixel HDISP*VDISP-1 -> DONE.
//   DONE : stb=0; FIFO keeps draining; frame_start -> same restart as from IDLE.
//   ABORT: entered on frame_start while stb=1 (the cycle is never dropped). Keep stb/adr
//          until ack; discard that data; then flush FIFO, restart at BASE_ADDR -> FETCH.
//          A frame_start in FETCH with stb=0 restarts immediately, bypassing ABORT.
//  Address: adr = BASE_ADDR + 2*cnt. cnt is 19 bits and never wraps within a frame.
//  FIFO: FWFT. pix_data is valid in the cycle pix_valid=1.
//   Pop on pix_valid&pix_rdy. Push on wb_ack in FETCH.
//   Simultaneous push and pop: count is unchanged and data order is preserved.
//   Never overflows, because of the DEPTH-1 guard.
//   Write-to-pix_valid latency on an empty FIFO: 1 cycle after ack.
//  underflow: set when pix_rdy=1 and pix_valid=0 in FETCH or DONE.
//   Cleared only by rst or by a frame_start restart. Ignored in IDLE and ABORT.
//  frame_start during reset: ignored. rst mid-cycle: stb drops immediately (slave must tolerate).
// TESTING
//  1 Reset, frame_start, pix_rdy=0, ack 1 cycle after stb -> exactly FIFO_DEPTH-1 reads,
//    adr 0,2,4..508; stb stays 0 afterwards; pix_valid=1 with pix_data=first word.
//  2 HDISP=4, VDISP=2, pix_rdy=1 continuously -> 8 reads, adr 0..14, 8 pixels in order,
//    state DONE, stb=0, underflow=1 (FIFO ran dry while pix_rdy was high).
//  3 frame_start while stb=1 and ack delayed 5 cycles -> stb/adr held for 5 cycles;
//    acked word not output; FIFO empty; next stb has adr=BASE_ADDR.
//  4 FIFO full minus 1 with push and pop in the same cycle -> count unchanged;
//    output order matches the ack data sequence.
//  5 Random ack delays 0-7 cycles, pix_rdy 50% duty, 3 frames with HDISP=8, VDISP=4 ->
//    scoreboard matches SDRAM model; wb_we=0 throughout; cyc==stb every cycle.
//  6 rst asserted mid-FETCH -> next cycle all outputs 0, FIFO empty, state IDLE.

Source files
------------

// File: rtl/wshb_fb_reader.sv
// Wishbone read master that streams the frame buffer from SDRAM, one 16-bit pixel per
// classic cycle, into a FWFT FIFO that feeds the display as a valid/ready stream.
module wshb_fb_reader #(
  parameter int          HDISP      = 640,
  parameter int          VDISP      = 480,
  parameter int          FIFO_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  output logic [31:0] wb_adr,
  input  logic [15:0] wb_dat_sm,
  input  logic        wb_ack,
  input  logic        frame_start,
  input  logic        pix_rdy,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        underflow
);

  localparam int          TOTAL    = HDISP * VDISP;
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [18:0] LAST_PIX = 19'(TOTAL - 1);
  localparam logic [AW:0] FILL_MAX = (AW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, ABORT, DONE} state_t;

  state_t         state_q, state_d;
  logic           stb_q, stb_d;
  logic [31:0]    adr_q, adr_d;
  logic [18:0]    cnt_q, cnt_d;
  logic           uf_q, uf_d;
  logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]    count_q, count_d;
  logic [15:0]    mem_q [FIFO_DEPTH];
  logic           push, pop, restart;

  assign pix_valid = (count_q != '0);
  assign pop       = pix_valid & pix_rdy;

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    uf_d    = uf_q;
    push    = 1'b0;
    restart = 1'b0;
    if (pix_rdy && !pix_valid && (state_q == FETCH || state_q == DONE)) uf_d = 1'b1;
    case (state_q)
      IDLE, DONE: if (frame_start) restart = 1'b1;
      FETCH: begin
        if (frame_start) begin
          // An outstanding cycle must complete; an ack arriving now completes it.
          if (stb_q && !wb_ack) begin
            state_d = ABORT;
            uf_d    = 1'b0;
          end else begin
            restart = 1'b1;
          end
        end else if (stb_q) begin
          if (wb_ack) begin
            push  = 1'b1;
            adr_d = adr_q + 32'd2;
            cnt_d = cnt_q + 19'd1;
            stb_d = 1'b0;
            if (cnt_q == LAST_PIX) state_d = DONE;
          end
        end else if (count_q < FILL_MAX) begin
          // One read in flight at most, so DEPTH-1 entries can never overflow.
          stb_d = 1'b1;
        end
      end
      ABORT: if (wb_ack) restart = 1'b1;
      default: state_d = IDLE;
    endcase
    if (restart) begin
      state_d = FETCH;
      stb_d   = 1'b0;
      adr_d   = BASE_ADDR;
      cnt_d   = '0;
      uf_d    = 1'b0;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (restart) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stb_q   <= 1'b0;
      adr_q   <= '0;
      cnt_q   <= '0;
      uf_q    <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      uf_q    <= uf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wb_dat_sm;
  end

  assign pix_data  = pix_valid ? mem_q[rptr_q] : 16'h0;
  assign wb_cyc    = stb_q;
  assign wb_stb    = stb_q;
  assign wb_adr    = adr_q;
  assign wb_we     = 1'b0;
  assign wb_sel    = 2'b11;
  assign wb_cti    = 3'b000;
  assign wb_bte    = 2'b00;
  assign underflow = uf_q;

endmodule

// File: tb/tb_wshb_fb_reader.sv
// Randomized bench for wshb_fb_reader: SDRAM slave model with variable ack delay and a
// queue-based model of the pixel stream checked every cycle.
module tb_wshb_fb_reader;
  localparam int          HD = 8, VD = 4, DEPTH = 8, TOTAL = HD * VD;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          M_IDLE = 0, M_RUN = 1, M_ABORT = 2, M_DONE = 3;

  logic        clk = 1'b0, rst = 1'b1;
  logic        wb_cyc, wb_stb, wb_we;
  logic [1:0]  wb_sel, wb_bte;
  logic [2:0]  wb_cti;
  logic [31:0] wb_adr;
  logic [15:0] wb_dat_sm = '0;
  logic        wb_ack = 1'b0, frame_start = 1'b0, pix_rdy = 1'b0;
  logic [15:0] pix_data;
  logic        pix_valid, underflow;

  always #5 clk = ~clk;

  wshb_fb_reader #(.HDISP(HD), .VDISP(VD), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_cti(wb_cti), .wb_bte(wb_bte), .wb_adr(wb_adr), .wb_dat_sm(wb_dat_sm), .wb_ack(wb_ack),
    .frame_start(frame_start), .pix_rdy(pix_rdy), .pix_data(pix_data), .pix_valid(pix_valid),
    .underflow(underflow));

  int vectors = 0, miscompares = 0;
  logic [15:0] q[$];
  int mode = M_IDLE, k = 0;
  bit uf = 1'b0;
  bit busy = 1'b0, rdy_on_ack = 1'b0;
  int scnt = 0, sdly = 0, dly_mode = 0;
  bit stb_prev = 1'b0, ack_prev = 1'b0, rst_prev = 1'b1, rose = 1'b0;
  int reads = 0, pops = 0, pairs = 0;
  logic [31:0] last_adr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sdram(input logic [31:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic check_outputs();
    logic [15:0] exp_d;
    exp_d = (q.size() != 0) ? q[0] : 16'h0;
    chk("pix_valid", 32'(pix_valid), 32'(q.size() != 0));
    chk("pix_data", 32'(pix_data), 32'(exp_d));
    chk("underflow", 32'(underflow), 32'(uf));
    chk("cyc_eq_stb", 32'(wb_cyc), 32'(wb_stb));
    chk("const_sigs", 32'({wb_we, wb_sel, wb_cti, wb_bte}), 32'(8'b0_11_000_00));
    if (wb_stb) chk("adr", wb_adr, BASE + 32'(2 * k));
    if (mode == M_IDLE || mode == M_DONE) chk("stb_idle", 32'(wb_stb), 32'd0);
    if (!rst_prev && stb_prev && !ack_prev) chk("stb_hold", 32'(wb_stb), 32'd1);
    if (stb_prev && ack_prev) chk("stb_gap", 32'(wb_stb), 32'd0);
    if (wb_stb && !stb_prev) begin
      chk("stb_rise_room", 32'(q.size() < DEPTH - 1), 32'd1);
      chk("stb_rise_mode", 32'(mode == M_RUN), 32'd1);
    end
  endtask

  task automatic m_restart();
    q.delete();
    k    = 0;
    uf   = 1'b0;
    mode = M_RUN;
  endtask

  task automatic m_pop(input bit rd);
    if (rd && q.size() != 0) begin
      void'(q.pop_front());
      pops++;
    end
  endtask

  task automatic model_update(input bit fs, input bit rd, input bit r, input bit a,
                              input logic [15:0] d, input bit stb);
    if (r) begin
      q.delete();
      mode = M_IDLE;
      k    = 0;
      uf   = 1'b0;
      return;
    end
    case (mode)
      M_IDLE: if (fs) m_restart(); else m_pop(rd);
      M_DONE: begin
        if (fs) m_restart();
        else begin
          if (rd && q.size() == 0) uf = 1'b1;
          m_pop(rd);
        end
      end
      M_RUN: begin
        if (fs) begin
          if (stb && !a) begin
            mode = M_ABORT;
            uf   = 1'b0;
            m_pop(rd);
          end else m_restart();
        end else begin
          if (rd && q.size() == 0) uf = 1'b1;
          m_pop(rd);
          if (stb && a) begin
            q.push_back(d);
            k++;
            if (k == TOTAL) mode = M_DONE;
          end
        end
      end
      default: if (stb && a) m_restart(); else m_pop(rd);
    endcase
  endtask

  // One clock: check outputs, run the slave, drive inputs, advance the model.
  task automatic step(input bit fs, input bit rdy, input bit r);
    bit a, rd;
    logic [15:0] d;
    @(negedge clk);
    check_outputs();
    a = 1'b0;
    d = 16'h0;
    if (r || ack_prev) busy = 1'b0;
    else if (wb_stb) begin
      if (!busy) begin
        busy = 1'b1;
        scnt = 0;
        sdly = (dly_mode < 0) ? int'($urandom_range(0, 7)) : dly_mode;
      end
      if (scnt == sdly) begin
        a    = 1'b1;
        d    = sdram(wb_adr);
        busy = 1'b0;
      end else scnt++;
    end else busy = 1'b0;
    rd = rdy_on_ack ? a : rdy;
    if (a && wb_stb) begin
      reads++;
      last_adr = wb_adr;
      if (rd) pairs++;
    end
    rose        = wb_stb && !stb_prev;
    wb_ack      = a;
    wb_dat_sm   = a ? d : 16'($urandom);
    frame_start = fs;
    pix_rdy     = rd;
    rst         = r;
    model_update(fs, rd, r, a, d, wb_stb);
    stb_prev = wb_stb;
    ack_prev = a;
    rst_prev = r;
  endtask

  task automatic wait_rise(input bit rdy);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1'b0, rdy, 1'b0);
      if (rose) begin
        ok = 1'b1;
        break;
      end
    end
    chk("stb_rise_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    bit ok;
    int held;
    logic [31:0] abort_adr;

    // Reset; frame_start during reset and pix_rdy in IDLE are both ignored.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("rst_adr", wb_adr, 32'h0);
    chk("rst_stb", 32'(wb_stb), 32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);

    // Display stalled: fetch stops at DEPTH-1 pixels.
    dly_mode = 1;
    reads = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);
    chk("t1_reads", 32'(reads), 32'd7);
    chk("t1_last_adr", last_adr, 32'h0000_100C);
    chk("t1_stb", 32'(wb_stb), 32'd0);
    chk("t1_valid", 32'(pix_valid), 32'd1);
    chk("t1_head", 32'(pix_data), 32'h4A5A);

    // Whole frame with display always ready: runs dry, sets underflow.
    dly_mode = 0;
    reads = 0;
    pops = 0;
    step(1'b1, 1'b1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (mode == M_DONE && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t2_timeout", 32'(ok), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    chk("t2_reads", 32'(reads), 32'd32);
    chk("t2_pops", 32'(pops), 32'd32);
    chk("t2_last_adr", last_adr, 32'h0000_103E);
    chk("t2_uf", 32'(underflow), 32'd1);
    chk("t2_stb", 32'(wb_stb), 32'd0);

    // frame_start while a read is outstanding: cycle held to ack, data dropped.
    dly_mode = 5;
    step(1'b1, 1'b0, 1'b0);
    wait_rise(1'b0);
    wait_rise(1'b0);
    wait_rise(1'b0);
    abort_adr = wb_adr;
    chk("t3_abort_adr", abort_adr, 32'h0000_1004);
    chk("t3_valid_before", 32'(pix_valid), 32'd1);
    held = 1;
    step(1'b1, 1'b0, 1'b0);
    if (wb_stb && wb_adr == abort_adr) held++;
    for (int i = 0; i < 20 && wb_stb; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (wb_stb && wb_adr == abort_adr) held++;
    end
    chk("t3_held", 32'(held), 32'd6);
    chk("t3_flushed", 32'(pix_valid), 32'd0);
    wait_rise(1'b0);
    chk("t3_restart_adr", wb_adr, BASE);

    // Push and pop in the same cycle at DEPTH-2 occupancy.
    step(1'b0, 1'b0, 1'b1);
    dly_mode = 2;
    reads = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100 && reads < 7; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    chk("t4_head0", 32'(pix_data), 32'h4A5A);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("t4_head1", 32'(pix_data), 32'h4A58);
    pairs = 0;
    rdy_on_ack = 1'b1;
    for (int i = 0; i < 200 && pairs < 10; i++) step(1'b0, 1'b0, 1'b0);
    rdy_on_ack = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("t4_pairs", 32'(pairs), 32'd10);
    chk("t4_reads", 32'(reads), 32'd17);
    chk("t4_head11", 32'(pix_data), 32'h4A4C);

    // Reset in the middle of a fetch.
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    wait_rise(1'b0);
    chk("t6_uf_before", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("t6_stb", 32'(wb_stb), 32'd0);
    chk("t6_cyc", 32'(wb_cyc), 32'd0);
    chk("t6_adr", wb_adr, 32'h0);
    chk("t6_valid", 32'(pix_valid), 32'd0);
    chk("t6_uf", 32'(underflow), 32'd0);

    // Three frames, random ack delays and random display back-pressure.
    dly_mode = -1;
    reads = 0;
    pops = 0;
    for (int f = 0; f < 3; f++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        if (mode == M_DONE && q.size() == 0) begin
          ok = 1'b1;
          break;
        end
      end
      chk("t5_frame_timeout", 32'(ok), 32'd1);
    end
    chk("t5_reads", 32'(reads), 32'd96);
    chk("t5_pops", 32'(pops), 32'd96);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
